// File: rtl/strobe_gen_pkg.sv
// Shared types and helpers for the multi-channel strobe generator.
// The config struct width tracks PKG_DIV_W; instantiate with DIV_W equal to it.
package strobe_gen_pkg;

  localparam int PKG_DIV_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_t;

  typedef struct packed {
    logic [PKG_DIV_W-1:0] div;
    logic [PKG_DIV_W-1:0] phase;
  } ch_cfg_t;

  // A start phase at or beyond the divider lands on the last count, so the
  // first strobe fires on the first RUN edge.
  function automatic logic [PKG_DIV_W-1:0] clamp_phase(input ch_cfg_t cfg);
    logic [PKG_DIV_W-1:0] res;
    if (cfg.div == '0)
      res = '0;
    else if (cfg.phase >= cfg.div)
      res = cfg.div - PKG_DIV_W'(1);
    else
      res = cfg.phase;
    return res;
  endfunction

endpackage

// File: rtl/strobe_channel.sv
// One strobe channel: counter, active and shadow config, pending flag and
// registered strobe. Shadow config lands on a period boundary while running.
module strobe_channel
  import strobe_gen_pkg::*;
#(
  parameter int          DIV_W       = PKG_DIV_W,
  parameter int unsigned DEFAULT_DIV = 240
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_run,
  input  logic    i_idle,
  input  logic    i_load,
  input  logic    i_wr,
  input  ch_cfg_t i_wr_cfg,
  output logic    o_strobe,
  output logic    o_pending
);

  ch_cfg_t          act;
  ch_cfg_t          shd;
  ch_cfg_t          load_cfg;
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // An arm edge consumes a same-cycle write or the pending shadow first.
  always_comb begin
    load_cfg = act;
    if (i_wr)
      load_cfg = i_wr_cfg;
    else if (o_pending)
      load_cfg = shd;
  end

  assign wrap = (act.div != '0) && (cnt == act.div - DIV_W'(1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      act       <= '{div: DIV_W'(DEFAULT_DIV), phase: '0};
      shd       <= '{div: DIV_W'(DEFAULT_DIV), phase: '0};
      cnt       <= '0;
      o_pending <= 1'b0;
      o_strobe  <= 1'b0;
    end else begin
      o_strobe <= 1'b0;
      if (i_load) begin
        act       <= load_cfg;
        shd       <= load_cfg;
        o_pending <= 1'b0;
        cnt       <= clamp_phase(load_cfg);
      end else begin
        if (i_wr) begin
          shd       <= i_wr_cfg;
          o_pending <= 1'b1;
        end
        if (i_run) begin
          if (act.div == '0) begin
            cnt <= '0;
            if (o_pending) begin
              act       <= shd;
              o_pending <= 1'b0;
            end
          end else if (wrap) begin
            cnt      <= '0;
            o_strobe <= 1'b1;
            if (o_pending) begin
              act       <= shd;
              o_pending <= 1'b0;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end else if (i_idle && o_pending) begin
          act       <= shd;
          o_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/strobe_gen_multi.sv
// Multi-channel programmable strobe generator: global arm/stop FSM, config
// port decode with per-channel ready, and N_CH phase-locked strobe channels.
module strobe_gen_multi
  import strobe_gen_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          DIV_W       = PKG_DIV_W,
  parameter int unsigned DEFAULT_DIV = 240,
  parameter int          CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_arm,
  input  logic             i_stop,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [DIV_W-1:0] i_cfg_phase,
  output logic [N_CH-1:0]  o_strobe,
  output logic             o_running,
  output logic [N_CH-1:0]  o_cfg_pending
);

  run_state_t      state;
  logic            idle;
  logic            arm_go;
  logic            run_cnt;
  logic [N_CH-1:0] wr;
  ch_cfg_t         wr_cfg;

  assign idle      = (state == IDLE);
  assign arm_go    = idle && i_arm && !i_stop;
  assign run_cnt   = (state == RUN) && !i_stop;
  assign o_running = (state == RUN);
  assign wr_cfg    = '{div: i_cfg_div, phase: i_cfg_phase};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      state <= IDLE;
    else if (arm_go)
      state <= RUN;
    else if ((state == RUN) && i_stop)
      state <= IDLE;
  end

  // Out-of-range channel selects match no channel: ready stays high, write dropped.
  always_comb begin
    o_cfg_ready = 1'b1;
    wr          = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (i_cfg_ch == CH_W'(i)) begin
        o_cfg_ready = !o_cfg_pending[i];
        wr[i]       = i_cfg_valid && !o_cfg_pending[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    strobe_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_run     (run_cnt),
      .i_idle    (idle),
      .i_load    (arm_go),
      .i_wr      (wr[g]),
      .i_wr_cfg  (wr_cfg),
      .o_strobe  (o_strobe[g]),
      .o_pending (o_cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Bench for strobe_gen_multi: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a countdown-based model.
module tb_strobe_gen_multi;

  localparam int NC = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_arm = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [2:0]  i_cfg_ch = '0;
  logic [15:0] i_cfg_div = '0;
  logic [15:0] i_cfg_phase = '0;
  logic [3:0]  o_strobe;
  logic        o_running;
  logic [3:0]  o_cfg_pending;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  strobe_gen_multi #(.N_CH(NC), .DIV_W(16), .DEFAULT_DIV(240), .CH_W(3)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_arm         (i_arm),
    .i_stop        (i_stop),
    .i_cfg_valid   (i_cfg_valid),
    .o_cfg_ready   (o_cfg_ready),
    .i_cfg_ch      (i_cfg_ch),
    .i_cfg_div     (i_cfg_div),
    .i_cfg_phase   (i_cfg_phase),
    .o_strobe      (o_strobe),
    .o_running     (o_running),
    .o_cfg_pending (o_cfg_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each channel counts down the edges left until its next strobe.
  bit m_run;
  int m_div[NC], m_ph[NC], m_sd[NC], m_sp[NC], m_togo[NC];
  bit m_pend[NC], m_strb[NC], acc[NC];

  task automatic model_reset();
    m_run = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_div[c] = 240; m_ph[c] = 0; m_sd[c] = 240; m_sp[c] = 0;
      m_togo[c] = 0; m_pend[c] = 1'b0; m_strb[c] = 1'b0;
    end
  endtask

  task automatic apply_shadow(input int c);
    m_div[c] = m_sd[c];
    m_ph[c] = m_sp[c];
    m_pend[c] = 1'b0;
  endtask

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < NC; c++)
        acc[c] = i_cfg_valid && (int'(i_cfg_ch) == c) && !m_pend[c];
      if (!m_run && i_arm && !i_stop) begin
        m_run = 1'b1;
        for (int c = 0; c < NC; c++) begin
          if (acc[c]) begin
            m_div[c] = int'(i_cfg_div); m_ph[c] = int'(i_cfg_phase);
          end else if (m_pend[c]) begin
            m_div[c] = m_sd[c]; m_ph[c] = m_sp[c];
          end
          m_pend[c] = 1'b0;
          m_strb[c] = 1'b0;
          if (m_div[c] == 0) m_togo[c] = 0;
          else if (m_ph[c] >= m_div[c]) m_togo[c] = 1;
          else m_togo[c] = m_div[c] - m_ph[c];
        end
      end else begin
        for (int c = 0; c < NC; c++) begin
          m_strb[c] = 1'b0;
          if (!m_run) begin
            if (m_pend[c]) apply_shadow(c);
          end else if (!i_stop) begin
            if (m_div[c] == 0) begin
              if (m_pend[c]) begin apply_shadow(c); m_togo[c] = m_div[c]; end
            end else begin
              m_togo[c]--;
              if (m_togo[c] == 0) begin
                m_strb[c] = 1'b1;
                if (m_pend[c]) apply_shadow(c);
                m_togo[c] = m_div[c];
              end
            end
          end
          if (acc[c]) begin
            m_sd[c] = int'(i_cfg_div); m_sp[c] = int'(i_cfg_phase); m_pend[c] = 1'b1;
          end
        end
        if (m_run && i_stop) m_run = 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en && !i_reset) begin
      logic [3:0] es, ep;
      logic       er;
      for (int c = 0; c < NC; c++) begin
        es[c] = m_strb[c];
        ep[c] = m_pend[c];
      end
      er = (int'(i_cfg_ch) >= NC) ? 1'b1 : !m_pend[i_cfg_ch[1:0]];
      chk("model_strobe", o_strobe, es);
      chk("model_running", o_running, m_run);
      chk("model_pending", o_cfg_pending, ep);
      chk("model_ready", o_cfg_ready, er);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input int d, input int p);
    i_cfg_ch = ch; i_cfg_div = 16'(d); i_cfg_phase = 16'(p); i_cfg_valid = 1'b1;
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic arm_pulse();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  task automatic default_run_check(input string tag);
    arm_pulse();
    chk({tag, "_running"}, o_running, 1'b1);
    chk({tag, "_arm_edge_strobe"}, o_strobe, 4'h0);
    for (int k = 1; k <= 480; k++) begin
      tick();
      chk({tag, "_strobe"}, o_strobe, (k % 240 == 0) ? 4'hF : 4'h0);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    repeat (3) tick();
    chk("reset_strobe", o_strobe, 4'h0);
    chk("reset_running", o_running, 1'b0);
    chk("reset_pending", o_cfg_pending, 4'h0);
    i_reset = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Defaults
    default_run_check("dflt");

    // Phases written in IDLE
    stop_pulse();
    chk("stop_running", o_running, 1'b0);
    cfg_write(3'd0, 4, 0);
    cfg_write(3'd1, 4, 2);
    cfg_write(3'd2, 1, 0);
    cfg_write(3'd3, 0, 0);
    tick();
    chk("idle_apply_pending", o_cfg_pending, 4'h0);
    arm_pulse();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("phase_strobe", o_strobe, {1'b0, 1'b1, (k % 4 == 2), (k % 4 == 0)});
    end

    // Mid-run reconfig of ch0 to D=6 at edge 5
    stop_pulse();
    arm_pulse();
    repeat (4) tick();
    i_cfg_ch = 3'd0; i_cfg_div = 16'd6; i_cfg_phase = 16'd0; i_cfg_valid = 1'b1;
    chk("reconf_ready_before", o_cfg_ready, 1'b1);
    tick();
    i_cfg_valid = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      chk("reconf_pending", o_cfg_pending[0], 1'b1);
      chk("reconf_ready_low", o_cfg_ready, 1'b0);
      tick();
    end
    chk("reconf_old_period_strobe", o_strobe[0], 1'b1);
    chk("reconf_pending_clear", o_cfg_pending[0], 1'b0);
    for (int k = 9; k <= 20; k++) begin
      tick();
      chk("reconf_new_period", o_strobe[0], (k == 14 || k == 20));
    end

    // Stop wins over arm, then re-arm restarts phases
    i_stop = 1'b1; i_arm = 1'b1;
    tick();
    i_stop = 1'b0; i_arm = 1'b0;
    chk("stoparm_running", o_running, 1'b0);
    chk("stoparm_strobe", o_strobe, 4'h0);
    repeat (3) begin
      tick();
      chk("stopped_strobe", o_strobe, 4'h0);
    end
    arm_pulse();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rearm_strobe", o_strobe, {1'b0, 1'b1, (k % 4 == 2), (k == 6)});
    end

    // Phase clamp and out-of-range channel
    stop_pulse();
    cfg_write(3'd0, 5, 9);
    tick();
    arm_pulse();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("clamp_strobe", o_strobe[0], (k == 1 || k == 6));
    end
    stop_pulse();
    i_cfg_ch = 3'd4; i_cfg_div = 16'd7; i_cfg_phase = 16'd3; i_cfg_valid = 1'b1;
    chk("badch_ready", o_cfg_ready, 1'b1);
    tick();
    i_cfg_valid = 1'b0;
    chk("badch_pending", o_cfg_pending, 4'h0);
    tick();
    arm_pulse();
    tick();
    chk("badch_unchanged", o_strobe, 4'b0101);
    stop_pulse();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      i_arm       = ($urandom_range(0, 9) == 0);
      i_stop      = ($urandom_range(0, 19) == 0);
      i_cfg_valid = ($urandom_range(0, 2) == 0);
      i_cfg_ch    = 3'($urandom_range(0, 5));
      i_cfg_div   = 16'($urandom_range(0, 7));
      i_cfg_phase = 16'($urandom_range(0, 9));
      tick();
    end
    i_arm = 1'b0; i_stop = 1'b0; i_cfg_valid = 1'b0; i_cfg_ch = 3'd0;

    // Async reset mid-run
    stop_pulse();
    arm_pulse();
    repeat (5) tick();
    i_reset = 1'b1;
    #1;
    chk("async_rst_strobe", o_strobe, 4'h0);
    chk("async_rst_running", o_running, 1'b0);
    chk("async_rst_pending", o_cfg_pending, 4'h0);
    #1;
    i_reset = 1'b0;
    tick();
    default_run_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
